alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Purpose: single-issue ALU with a valid/ready request side and a valid/ready
// result side. Logic and add/sub operations complete in one cycle. MUL is an
// iterative shift-add that consumes one multiplier bit per cycle over WIDTH
// cycles. The result and flags are held stable until the consumer takes them.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready only in IDLE)
//   control_line[3:0]        operation code
//   a, b [WIDTH-1:0]         operands
//   out_valid / out_ready    result handshake
//   result [WIDTH-1:0]       registered result
//   zero, negative, carry, overflow   registered condition flags
//   illegal                  registered; accepted code was undefined
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control_line,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             ill;
  } alu_out_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_p0, mplier_p0, acc_p0;
  logic [WIDTH-1:0] acc_next;
  logic             accept, is_mul, mul_last, wr_en;
  alu_out_t         wb;

  // Single-cycle operations. Result and carry/overflow only; zero and
  // negative are derived from whichever result is finally written back.
  function automatic alu_out_t alu_eval(input logic [3:0]              op,
                                        input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y);
    alu_out_t   o;
    logic [WIDTH:0] wide;
    o    = '0;
    wide = '0;
    case (op)
      OP_AND:  o.res = x & y;
      OP_ORR:  o.res = x | y;
      OP_NOR:  o.res = ~(x | y);
      OP_PASS: o.res = y;
      OP_ADD: begin
        wide  = {1'b0, x} + {1'b0, y};
        o.res = wide[WIDTH-1:0];
        o.c   = wide[WIDTH];
        o.v   = (x[WIDTH-1] == y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // The extended top bit is the borrow; carry means "no borrow".
        wide  = {1'b0, x} - {1'b0, y};
        o.res = wide[WIDTH-1:0];
        o.c   = ~wide[WIDTH];
        o.v   = (x[WIDTH-1] != y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_MUL:  o.res = '0;  // produced by the iterative path instead
      default: o.ill = 1'b1;
    endcase
    return o;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (control_line == OP_MUL);
  assign mul_last  = (state_q == BUSY) && (cnt_q == CNT_W'(WIDTH - 1));
  assign wr_en     = (accept && !is_mul) || mul_last;
  assign acc_next  = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

  always_comb begin
    wb = alu_eval(control_line, $signed(a), $signed(b));
    if (mul_last) begin
      wb.res = acc_next;
      wb.c   = 1'b0;
      wb.v   = 1'b0;
      wb.ill = 1'b0;
    end
    wb.z = (wb.res == '0);
    wb.n = wb.res[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? BUSY : HOLD;
      BUSY:    if (mul_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (accept)          cnt_q <= '0;
    else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
  end

  // Stage p0: multiplier working registers, loaded on acceptance so input
  // changes during BUSY cannot disturb the product.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_p0  <= a;
      mplier_p0 <= b;
      acc_p0    <= '0;
    end else if (state_q == BUSY) begin
      acc_p0    <= acc_next;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // Stage p1: architectural result and flags, written only at completion
  // so they stay frozen throughout HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (wr_en) begin
      result   <= wb.res;
      zero     <= wb.z;
      negative <= wb.n;
      carry    <= wb.c;
      overflow <= wb.v;
      illegal  <= wb.ill;
    end
  end

endmodule
